// File: rtl/fibonacci_index_finder_if.sv
// Purpose: request/result bundle for the Fibonacci index finder.
// Latency: none (wires only).
// Backpressure: none; the requester holds begin_search and watches busy/done.
interface fibonacci_index_finder_if;
  logic        begin_search;
  logic [15:0] fibo_in;
  logic        busy;
  logic        done;
  logic        found;
  logic [4:0]  index_out;

  // Requester side: drives the start and the candidate, observes status/result
  modport master (
    output begin_search,
    output fibo_in,
    input  busy,
    input  done,
    input  found,
    input  index_out
  );

  // Finder side
  modport slave (
    input  begin_search,
    input  fibo_in,
    output busy,
    output done,
    output found,
    output index_out
  );
endinterface

// File: rtl/fibonacci_index_finder.sv
// Purpose: find the smallest n with F(n) == fibo_in by stepping the sequence forward.
// Latency: done rises n+1 edges after the start edge (26 worst case, for inputs >= 46369).
// Backpressure: result held in DONE until begin_search drops; a held start never re-triggers.
module fibonacci_index_finder (
  input  logic                            clk,
  input  logic                            reset_n,
  fibonacci_index_finder_if.slave         bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SEARCH = 2'b01,
    DONE   = 2'b10
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [15:0] target;
  // 17 bits so the term one past 65535 (F(25)) and its successor F(26) never wrap
  logic [16:0] a;
  logic [16:0] b;
  logic [4:0]  idx;
  logic        found_q;
  logic [4:0]  index_q;

  logic        hit;
  logic        overshoot;

  assign hit       = (a == {1'b0, target});
  assign overshoot = (a >  {1'b0, target});

  // State register; reset drops straight to IDLE without a clock
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and status flags; the spare encoding falls back to IDLE
  always_comb begin
    state_nxt = IDLE;
    bus.busy  = 1'b0;
    bus.done  = 1'b0;
    case (state)
      IDLE: begin
        state_nxt = bus.begin_search ? SEARCH : IDLE;
      end
      SEARCH: begin
        bus.busy  = 1'b1;
        state_nxt = (hit || overshoot) ? DONE : SEARCH;
      end
      DONE: begin
        bus.done  = 1'b1;
        // Leave only once the requester has released begin_search
        state_nxt = bus.begin_search ? DONE : IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Search datapath: latch candidate at start, walk (a,b) until a reaches or passes it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      target  <= 16'd0;
      a       <= 17'd0;
      b       <= 17'd1;
      idx     <= 5'd0;
      found_q <= 1'b0;
      index_q <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.begin_search) begin
            target  <= bus.fibo_in;
            a       <= 17'd0;
            b       <= 17'd1;
            idx     <= 5'd0;
            found_q <= 1'b0;
            index_q <= 5'd0;
          end
        end
        SEARCH: begin
          // Equality is checked first so F(1)=F(2)=1 reports the smaller index
          if (hit) begin
            found_q <= 1'b1;
            index_q <= idx;
          end else if (overshoot) begin
            found_q <= 1'b0;
            index_q <= 5'd0;
          end else begin
            a   <= b;
            b   <= a + b;
            idx <= idx + 5'd1;
          end
        end
        default: begin
          // DONE and the spare encoding hold the last result
        end
      endcase
    end
  end

  assign bus.found     = found_q;
  assign bus.index_out = index_q;

endmodule

// File: tb/tb_fibonacci_index_finder.sv
// Purpose: scoreboard bench for fibonacci_index_finder.
// Latency: expected done edge is computed per request and compared to the observed edge.
// Backpressure: exercises begin_search held high through DONE.
module tb_fibonacci_index_finder;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  fibonacci_index_finder_if bus ();

  fibonacci_index_finder dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic       found;
    logic [4:0] index;
    int         latency;
  } exp_t;

  exp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: walk the sequence in plain integers and push the expected result
  task automatic push_expect(input logic [15:0] v);
    exp_t e;
    int   fa, fb, t, n;
    fa = 0; fb = 1; n = 0;
    while (fa < int'(v)) begin
      t  = fa + fb;
      fa = fb;
      fb = t;
      n++;
    end
    e.found   = (fa == int'(v));
    e.index   = e.found ? 5'(n) : 5'd0;
    e.latency = n + 1;
    sb.push_back(e);
  endtask

  // Drive one start edge; returns at the negedge after E0
  task automatic start_search(input string tag, input logic [15:0] v, input bit hold);
    push_expect(v);
    @(negedge clk);
    bus.fibo_in      = v;
    bus.begin_search = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, "_busy_E0"}, 32'(bus.busy), 32'd1);
    chk({tag, "_clr_found"}, 32'(bus.found), 32'd0);
    chk({tag, "_clr_index"}, 32'(bus.index_out), 32'd0);
    @(negedge clk);
    if (!hold) bus.begin_search = 1'b0;
    // Later input changes must not matter
    bus.fibo_in = ~v;
  endtask

  // Count edges until done, then pop and compare
  task automatic wait_result(input string tag);
    exp_t e;
    int   cyc;
    bit   both;
    bit   busy_gap;
    cyc = 0; both = 1'b0; busy_gap = 1'b0;
    while (cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.busy && bus.done) both = 1'b1;
      if (bus.done) break;
      if (!bus.busy) busy_gap = 1'b1;
    end
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_latency"}, 32'(cyc), 32'(e.latency));
      chk({tag, "_found"}, 32'(bus.found), 32'(e.found));
      chk({tag, "_index"}, 32'(bus.index_out), 32'(e.index));
    end
    chk({tag, "_busy_done_overlap"}, 32'(both), 32'd0);
    chk({tag, "_busy_gap"}, 32'(busy_gap), 32'd0);
  endtask

  task automatic run_one(input string tag, input logic [15:0] v);
    start_search(tag, v, 1'b0);
    wait_result(tag);
    // Next edge returns to IDLE; result must be retained there
    @(posedge clk);
    #1;
    chk({tag, "_idle_done"}, 32'(bus.done), 32'd0);
    @(posedge clk);
    #1;
    if (sb.size() == 0) chk({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
  endtask

  logic [15:0] rv;
  logic        keep_found;
  logic [4:0]  keep_index;

  initial begin
    bus.begin_search = 1'b0;
    bus.fibo_in      = 16'd0;
    reset_n          = 1'b0;
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_found", 32'(bus.found), 32'd0);
    chk("rst_index", 32'(bus.index_out), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    run_one("f0", 16'd0);
    run_one("f1", 16'd1);
    run_one("f55", 16'd55);
    // Result retained in IDLE
    keep_found = bus.found;
    keep_index = bus.index_out;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_keep_found", 32'(bus.found), 32'd1);
    chk("idle_keep_index", 32'(bus.index_out), 32'd10);
    run_one("f46368", 16'd46368);
    run_one("nf4", 16'd4);
    run_one("nf65535", 16'd65535);
    run_one("f2", 16'd2);
    run_one("f46369", 16'd46369);

    // begin_search held through DONE: no restart, exit one edge after release
    start_search("hold13", 16'd13, 1'b1);
    wait_result("hold13");
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("hold_done", 32'(bus.done), 32'd1);
      chk("hold_busy", 32'(bus.busy), 32'd0);
    end
    @(negedge clk);
    bus.begin_search = 1'b0;
    @(posedge clk);
    #1;
    chk("hold_release_done", 32'(bus.done), 32'd0);
    chk("hold_release_found", 32'(bus.found), 32'd1);
    chk("hold_release_index", 32'(bus.index_out), 32'd7);
    @(posedge clk);
    #1;
    chk("hold_release_busy", 32'(bus.busy), 32'd0);

    // Reset pulsed at E5 of a 55 search
    start_search("rst55", 16'd55, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    chk("midrst_found", 32'(bus.found), 32'd0);
    chk("midrst_index", 32'(bus.index_out), 32'd0);
    void'(sb.pop_front());
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    run_one("post_rst55", 16'd55);

    // Random candidates
    for (int i = 0; i < 6; i++) begin
      rv = 16'($urandom_range(0, 65535));
      run_one("rand", rv);
    end
    // Small values land on Fibonacci numbers more often
    for (int i = 0; i < 6; i++) begin
      rv = 16'($urandom_range(0, 100));
      run_one("rand_small", rv);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fibonacci_index_finder.md
FIBONACCI_INDEX_FINDER -- requirements
Module: fibonacci_index_finder

Interface
REQ-001 The block SHALL have no parameters; the data width is fixed at 16 bits and the index width at 5 bits.
REQ-002 clk  input  1  single clock; all state changes occur on the rising edge.
REQ-003 reset_n  input  1  reset, asynchronous and active-low.
REQ-004 begin_search  input  1  start request, level-sampled in IDLE.
REQ-005 fibo_in  input  16  candidate value to invert, latched when the start is accepted.
REQ-006 busy  output  1  high while in SEARCH.
REQ-007 done  output  1  high while in DONE.
REQ-008 found  output  1  result flag: fibo_in is a Fibonacci number.
REQ-009 index_out  output  5  smallest n with F(n) == latched value; 0 when not found.

Function
REQ-010 Sequence definition SHALL be F(0)=0, F(1)=1, F(n)=F(n-1)+F(n-2), matching the team's forward calculator indexing.
REQ-011 State machine SHALL have three states, IDLE, SEARCH and DONE, and SHALL be encoded in a 2-bit register; the unused encoding SHALL return to IDLE.
REQ-012 IDLE: when begin_search=1 at an edge (start edge E0), the block SHALL:
  - latch fibo_in into target;
  - set a=0, b=1, idx=0;
  - go to SEARCH.
  Otherwise it SHALL remain in IDLE.
REQ-013 fibo_in SHALL be ignored outside the start edge; later changes SHALL NOT affect the result.
REQ-014 SEARCH, per edge, evaluated in priority order:
  - if a == target: found<=1, index_out<=idx, go to DONE;
  - else if a > target: found<=0, index_out<=0, go to DONE;
  - else: a<=b, b<=a+b, idx<=idx+1.
REQ-015 Registers a and b SHALL be 17 bits wide and compared zero-extended against target, so the sequence up to F(26)=121393 is represented without wrap.
REQ-016 Latency: for target=F(n), done SHALL rise at edge E(n+1).
REQ-017 Latency: for a non-Fibonacci target, done SHALL rise at edge E(k+1), where F(k) is the first term greater than target.
REQ-018 Worst-case latency SHALL be 26 cycles, reached for targets in 46369..65535.
REQ-019 The value 1 SHALL report index 1, the smallest matching index, not index 2.
REQ-020 DONE: done=1 and found/index_out SHALL be held stable.
REQ-021 The block SHALL leave DONE for IDLE only at the first edge with begin_search=0, clearing done at that edge.
REQ-022 A begin_search held high through DONE SHALL NOT start a new search.
REQ-023 In IDLE, found and index_out SHALL retain the last result until the next start edge.
REQ-024 At the start edge, found and index_out SHALL be cleared to 0.
REQ-025 busy and done SHALL never be high simultaneously.
REQ-026 busy SHALL be high from E0+1 through the edge at which done rises.

Reset
REQ-027 Asserting reset_n=0 SHALL immediately force, without waiting for clk:
  - state=IDLE;
  - busy=0, done=0, found=0, index_out=0;
  - target=0, a=0, b=1, idx=0.
REQ-028 Reset asserted mid-SEARCH or in DONE SHALL abort the operation with no residual result.
REQ-029 After reset_n is deasserted, the first accepted start SHALL behave identically to a start from power-up.

Verification
REQ-030 fibo_in=0, begin pulse -> done at E1, found=1, index_out=0.
REQ-031 fibo_in=1 -> done at E2, found=1, index_out=1.
REQ-032 fibo_in=55 -> done at E11, found=1, index_out=10.
REQ-033 fibo_in=46368 -> done at E25, found=1, index_out=24.
REQ-034 Not-found cases:
  - fibo_in=4 -> done at E6, found=0, index_out=0;
  - fibo_in=65535 -> done at E26, found=0, index_out=0.
REQ-035 Handshake and reset cases:
  - begin_search held high through DONE -> no restart; done clears one edge after begin_search=0;
  - reset_n pulsed low at E5 of a 55 search -> all outputs 0 immediately;
  - a subsequent 55 search -> index_out=10.
